// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states
// and the select encodings seen by the datapath muxes and ALU decoder.
package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_REL    = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_LINK   = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [2:0] {
        START,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from the ALU compare flags; `valid` is low for funct3
// codes the core does not implement (the unsigned compares).
module branch_cond
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    output logic       taken,
    output logic       valid
);

    always_comb begin
        taken = 1'b0;
        valid = 1'b1;
        case (funct3)
            F3_BEQ:  taken = alu_zero;
            F3_BNE:  taken = !alu_zero;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = !alu_lt;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over
// one shared memory port, drives all datapath controls, counts retirements.
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             halt,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t           state;
    state_t           state_nxt;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;
    logic             br_taken;
    logic             br_valid;
    logic             retire;

    branch_cond u_branch_cond (
        .funct3   (funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .taken    (br_taken),
        .valid    (br_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= START;
        else
            state <= state_nxt;
    end

    // HALT is only reachable from DECODE, so this flag marks an unsupported encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (state == DECODE && state_nxt == HALT)
            illegal_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + CNT_W'(1);
    end

    assign retire  = (state_nxt == FETCH) &&
                     (state == EXEC || state == MEM || state == WB);
    assign illegal = illegal_q;
    assign instret = instret_q;

    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        halt         = 1'b0;

        case (state)
            START: state_nxt = FETCH;

            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    pc_src    = PC_PLUS4;
                    state_nxt = DECODE;
                end
            end

            DECODE: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR:
                        state_nxt = EXEC;
                    OPC_BRANCH: state_nxt = br_valid ? EXEC : HALT;
                    OPC_JAL, OPC_LUI: state_nxt = WB;
                    default:    state_nxt = HALT;
                endcase
            end

            EXEC: begin
                case (opcode)
                    OPC_OP: begin
                        alu_op    = ALU_FUNCT;
                        state_nxt = WB;
                    end
                    OPC_OP_IMM: begin
                        alu_op    = ALU_FUNCT;
                        alu_src_b = 1'b1;
                        state_nxt = WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_b = 1'b1;
                        state_nxt = MEM;
                    end
                    OPC_JALR: begin
                        alu_src_b = 1'b1;
                        state_nxt = WB;
                    end
                    OPC_BRANCH: begin
                        alu_op    = ALU_SUB;
                        pc_we     = br_taken;
                        pc_src    = PC_REL;
                        state_nxt = FETCH;
                    end
                    default: state_nxt = HALT;
                endcase
            end

            // Address stays on the ALU (add, imm) for the whole access.
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OPC_STORE);
                alu_src_b    = 1'b1;
                if (mem_ready)
                    state_nxt = (opcode == OPC_STORE) ? FETCH : WB;
            end

            WB: begin
                rf_we     = 1'b1;
                state_nxt = FETCH;
                case (opcode)
                    OPC_LOAD: wb_sel = WB_MEM;
                    OPC_LUI:  wb_sel = WB_IMM;
                    OPC_JAL: begin
                        wb_sel = WB_LINK;
                        pc_we  = 1'b1;
                        pc_src = PC_REL;
                    end
                    OPC_JALR: begin
                        wb_sel    = WB_LINK;
                        pc_we     = 1'b1;
                        pc_src    = PC_JALR;
                        alu_src_b = 1'b1;
                    end
                    default:  wb_sel = WB_ALU;
                endcase
            end

            HALT: halt = 1'b1;

            default: state_nxt = START;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected control vectors go through
// a scoreboard queue; a narrow counter exercises instret wrap-around.
module tb_mc_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int CNT_W = 3;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       halt;
        logic       illegal;
    } out_t;

    typedef struct {
        out_t             o;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             alu_zero;
    logic             alu_lt;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             halt;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] model_ret = '0;

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .halt         (halt),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic mr, mw, mas, irw, pcw, input logic [1:0] ps,
                                input logic sbb, input logic [1:0] ao, input logic rf,
                                input logic [1:0] wb, input logic h, il);
        out_t o;
        o = '{mr, mw, mas, irw, pcw, ps, sbb, ao, rf, wb, h, il};
        return o;
    endfunction

    function automatic out_t o_zero();
        return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0);
    endfunction

    function automatic out_t o_fetch(input logic r);
        return mk(1, 0, 0, r, r, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0);
    endfunction

    function automatic out_t o_branch(input logic t);
        return mk(0, 0, 0, 0, t, 2'b01, 0, 2'b01, 0, 2'b00, 0, 0);
    endfunction

    function automatic out_t o_mem(input logic w);
        return mk(1, w, 1, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0);
    endfunction

    function automatic out_t o_wb(input logic [1:0] wb);
        return mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, wb, 0, 0);
    endfunction

    task automatic checkOutput();
        exp_t e;
        out_t obs;
        e   = sb.pop_front();
        obs = '{mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
                alu_op, rf_we, wb_sel, halt, illegal};
        checks += 2;
        assert (obs === e.o) else begin
            errors++;
            $error("[TB] FAIL %s controls: observed=%h expected=%h", e.tag, obs, e.o);
        end
        assert (instret === e.cnt) else begin
            errors++;
            $error("[TB] FAIL %s instret: observed=%0d expected=%0d", e.tag, instret, e.cnt);
        end
    endtask

    // One clock cycle: drive inputs, record expectation, sample, advance.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic z, lt, rdy, input out_t o,
                                 input bit ret, input string tag);
        opcode    = op;
        funct3    = f3;
        alu_zero  = z;
        alu_lt    = lt;
        mem_ready = rdy;
        sb.push_back('{o, model_ret, tag});
        #1;
        checkOutput();
        @(posedge clk);
        if (ret)
            model_ret = model_ret + 1'b1;
        @(negedge clk);
    endtask

    task automatic fetchDecode(input logic [6:0] op, input logic [2:0] f3, input string tag);
        applyStimulus(op, f3, 0, 0, 1, o_fetch(1), 0, {tag, "_fetch"});
        applyStimulus(op, f3, 0, 0, 1, o_zero(), 0, {tag, "_decode"});
    endtask

    task automatic runBranch(input logic [2:0] f3, input logic z, lt, t, input string tag);
        fetchDecode(OPC_BRANCH, f3, tag);
        applyStimulus(OPC_BRANCH, f3, z, lt, 1, o_branch(t), 1, {tag, "_exec"});
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = '0;
        funct3    = '0;
        alu_zero  = 1'b0;
        alu_lt    = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);

        applyStimulus(OPC_OP_IMM, 3'b000, 0, 0, 1, o_zero(), 0, "in_reset");
        rst_n = 1'b1;
        applyStimulus(OPC_OP_IMM, 3'b000, 0, 0, 1, o_zero(), 0, "start");

        // addi x1, x0, 5 with zero wait states
        fetchDecode(OPC_OP_IMM, 3'b000, "addi");
        applyStimulus(OPC_OP_IMM, 3'b000, 0, 0, 1,
                      mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 2'b00, 0, 0), 0, "addi_exec");
        applyStimulus(OPC_OP_IMM, 3'b000, 0, 0, 1, o_wb(WB_ALU), 1, "addi_wb");

        // lw with two memory wait states
        fetchDecode(OPC_LOAD, 3'b010, "lw");
        applyStimulus(OPC_LOAD, 3'b010, 0, 0, 1,
                      mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0), 0, "lw_exec");
        applyStimulus(OPC_LOAD, 3'b010, 0, 0, 0, o_mem(0), 0, "lw_mem_wait1");
        applyStimulus(OPC_LOAD, 3'b010, 0, 0, 0, o_mem(0), 0, "lw_mem_wait2");
        applyStimulus(OPC_LOAD, 3'b010, 0, 0, 1, o_mem(0), 0, "lw_mem_done");
        applyStimulus(OPC_LOAD, 3'b010, 0, 0, 1, o_wb(WB_MEM), 1, "lw_wb");

        // sw with one fetch wait state, zero-wait memory
        applyStimulus(OPC_STORE, 3'b010, 0, 0, 0, o_fetch(0), 0, "sw_fetch_wait");
        fetchDecode(OPC_STORE, 3'b010, "sw");
        applyStimulus(OPC_STORE, 3'b010, 0, 0, 1,
                      mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0), 0, "sw_exec");
        applyStimulus(OPC_STORE, 3'b010, 0, 0, 1, o_mem(1), 1, "sw_mem");

        runBranch(F3_BEQ, 1, 0, 1, "beq_taken");
        runBranch(F3_BEQ, 0, 0, 0, "beq_not");
        runBranch(F3_BLT, 0, 1, 1, "blt_taken");
        runBranch(F3_BGE, 0, 1, 0, "bge_not");
        runBranch(F3_BNE, 0, 0, 1, "bne_taken");

        fetchDecode(OPC_JAL, 3'b000, "jal");
        applyStimulus(OPC_JAL, 3'b000, 0, 0, 1,
                      mk(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 1, 2'b10, 0, 0), 1, "jal_wb");

        fetchDecode(OPC_LUI, 3'b000, "lui");
        applyStimulus(OPC_LUI, 3'b000, 0, 0, 1, o_wb(WB_IMM), 1, "lui_wb");

        fetchDecode(OPC_JALR, 3'b000, "jalr");
        applyStimulus(OPC_JALR, 3'b000, 0, 0, 1,
                      mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0), 0, "jalr_exec");
        applyStimulus(OPC_JALR, 3'b000, 0, 0, 1,
                      mk(0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 1, 2'b10, 0, 0), 1, "jalr_wb");

        fetchDecode(OPC_OP, 3'b000, "add");
        applyStimulus(OPC_OP, 3'b000, 0, 0, 1,
                      mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, 2'b00, 0, 0), 0, "add_exec");
        applyStimulus(OPC_OP, 3'b000, 0, 0, 1, o_wb(WB_ALU), 1, "add_wb");

        // Store interrupted by reset while waiting in MEM
        fetchDecode(OPC_STORE, 3'b010, "sw_rst");
        applyStimulus(OPC_STORE, 3'b010, 0, 0, 0,
                      mk(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0), 0, "sw_rst_exec");
        mem_ready = 1'b0;
        sb.push_back('{o_mem(1), model_ret, "sw_rst_mem"});
        #1;
        checkOutput();
        #1;
        rst_n     = 1'b0;
        model_ret = '0;
        #1;
        sb.push_back('{o_zero(), model_ret, "sw_rst_async"});
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(OPC_LUI, 3'b000, 0, 0, 1, o_zero(), 0, "rst_start");
        fetchDecode(OPC_LUI, 3'b000, "rst_lui");
        applyStimulus(OPC_LUI, 3'b000, 0, 0, 1, o_wb(WB_IMM), 1, "rst_lui_wb");

        // Unsupported opcode halts; mem_ready must be ignored while halted
        fetchDecode(7'h7F, 3'b000, "bad_op");
        for (int i = 0; i < 20; i++)
            applyStimulus(7'h7F, 3'b000, 0, 0, 1,
                          mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 1, 1), 0, "bad_op_halt");

        rst_n     = 1'b0;
        model_ret = '0;
        #1;
        sb.push_back('{o_zero(), model_ret, "halt_reset"});
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(OPC_BRANCH, 3'b010, 0, 0, 1, o_zero(), 0, "f3_start");
        fetchDecode(OPC_BRANCH, 3'b010, "bad_f3");
        for (int i = 0; i < 5; i++)
            applyStimulus(OPC_BRANCH, 3'b010, 1, 1, 1,
                          mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 1, 1), 0, "bad_f3_halt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control state machine for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback over a single shared memory port, and drives every datapath enable and mux select. The instruction register it loads feeds the immediate generator, register file and ALU. It also counts retired instructions and halts on unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `alu_zero`  in  1  ALU result == 0
- `alu_lt`  in  1  signed rs1 < rs2
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_addr_sel`  out  1  0 = PC, 1 = ALU result
- `ir_we`  out  1  load IR and old_pc (old_pc = PC)
- `pc_we`  out  1  PC write enable
- `pc_src`  out  2  00 = PC+4, 01 = old_pc+imm, 10 = ALU result with bit0 cleared
- `alu_src_b`  out  1  0 = rs2, 1 = imm
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct decode
- `rf_we`  out  1  register file write
- `wb_sel`  out  2  00 = ALU, 01 = mem data, 10 = old_pc+4, 11 = imm
- `halt`  out  1  sticky halt
- `illegal`  out  1  sticky: halt was caused by an unsupported opcode or funct3
- `instret`  out  CNT_W  retired-instruction count

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB, HALT.
- START: all outputs 0. Goes unconditionally to FETCH.
- FETCH: `mem_req`=1, `mem_addr_sel`=0. On `mem_ready`, pulse `ir_we` and `pc_we` with `pc_src`=00, then go to DECODE.
- DECODE: all outputs 0. Next state by opcode:
  - 0110011, 0010011, 0000011, 0100011, 1100011, 1100111 go to EXEC.
  - 1101111 (JAL) and 0110111 (LUI) go to WB.
  - Any other opcode goes to HALT.
  - Branch with funct3 not in {000, 001, 100, 101} goes to HALT.
- EXEC:
  - OP (0110011): `alu_op`=10, `alu_src_b`=0. Next: WB.
  - OP-IMM (0010011): `alu_op`=10, `alu_src_b`=1. Next: WB.
  - LOAD/STORE/JALR: `alu_op`=00, `alu_src_b`=1. Next: MEM for LOAD/STORE, WB for JALR.
  - BRANCH: `alu_op`=01, `alu_src_b`=0. `pc_we`=taken, `pc_src`=01. Next: FETCH (retire).
  - Taken conditions: beq = zero, bne = !zero, blt = lt, bge = !lt.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE. ALU inputs are held as in EXEC.
  - On `mem_ready`: LOAD goes to WB; STORE goes to FETCH (retire).
- WB: `rf_we`=1.
  - OP/OP-IMM: `wb_sel`=00.
  - LOAD: `wb_sel`=01.
  - LUI: `wb_sel`=11.
  - JAL: `wb_sel`=10, `pc_we`=1, `pc_src`=01.
  - JALR: `wb_sel`=10, `pc_we`=1, `pc_src`=10, `alu_op`=00, `alu_src_b`=1.
  - Next: FETCH (retire).
- Retire: `instret` increments by 1 on each transition into FETCH from EXEC, MEM or WB. It wraps modulo 2^CNT_W.
- HALT: absorbing state. `halt`=1; `illegal`=1 when entered from DECODE. All other outputs 0; `instret` frozen. Only reset exits.

## Timing
- Reset (async, any state): state = START, `instret` = 0, every output 0. The first `mem_req` appears 1 cycle after `rst_n` rises.
- Memory handshake:
  - `mem_req`, `mem_we` and `mem_addr_sel` stay stable until `mem_ready` is sampled high.
  - `mem_ready` is ignored while `mem_req`=0.
  - Zero-wait-state operation is legal: `mem_ready` high in the first cycle of FETCH or MEM.
- `ir_we`, `pc_we` in FETCH and branch `pc_we` are Mealy outputs. All other outputs are Moore.
- Latency with zero wait states:
  - OP/OP-IMM/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - JAL/LUI: 3 cycles.
  - Each wait state adds 1 cycle.
- Reset asserted mid-MEM drops `mem_req` immediately. No retire occurs.

## Structure
- Package `ctrl_pkg`: opcode localparams, state enum, and the `pc_src`, `wb_sel` and `alu_op` encodings. The ALU decoder and datapath muxes import the same package.
- Sub-module `branch_cond`: combinational; inputs `funct3`, `alu_zero`, `alu_lt`; outputs `taken` and `valid`.
- Top level: state register, next-state logic, output decode, `instret` counter.

## Test plan
- Reset release with `mem_ready`=1: START then FETCH; `ir_we` and `pc_we` pulse in cycle 2; `instret`=0.
- addi (0x00500093), ready tied high: path FETCH→DECODE→EXEC→WB. `rf_we`=1 with `wb_sel`=00 in WB. `instret` goes 0→1 on re-entering FETCH.
- lw with 2 wait states in MEM: `mem_req`=1, `mem_addr_sel`=1 and `mem_we`=0 held for 3 cycles. WB follows with `wb_sel`=01; total latency 7 cycles.
- beq with `alu_zero`=1: `pc_we`=1, `pc_src`=01 in EXEC. Repeat with `alu_zero`=0: `pc_we`=0. Both cases retire.
- Opcode 0x7F, or branch funct3=010: DECODE→HALT. `halt`=1 and `illegal`=1; `mem_req` stays 0 for 20 cycles; `instret` unchanged.
- `rst_n` pulled low mid-MEM (store): `mem_req` and `mem_we` drop asynchronously; `instret`=0. Normal fetch resumes after release.
